// File: rtl/bitsixtyfour_drive_capture.sv
// Rail driver and result capture for the 64-bit CMOS compare array.
// Buffers x/k operands, drives true/complement rails for a settle window, then counts matches.
module bitsixtyfour_drive_capture #(
  parameter int BIT_SIZE = 64,
  parameter int SETTLE_W = 8,
  parameter int CNT_W    = 7
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wr_en,
  input  logic [1:0]          wr_addr,
  input  logic [31:0]         wr_data,
  input  logic                start,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic                busy,
  output logic                done,
  output logic [BIT_SIZE-1:0] x,
  output logic [BIT_SIZE-1:0] x_bar,
  output logic [BIT_SIZE-1:0] k,
  output logic [BIT_SIZE-1:0] k_bar,
  input  logic [BIT_SIZE-1:0] s_in,
  output logic [BIT_SIZE-1:0] s_cap,
  output logic [CNT_W-1:0]    match_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_DRIVE = 2'd2,
    ST_CAP   = 2'd3
  } state_t;

  state_t                r_state;
  logic [BIT_SIZE-1:0]   r_x_sh;
  logic [BIT_SIZE-1:0]   r_k_sh;
  logic [BIT_SIZE-1:0]   r_x_d;
  logic [BIT_SIZE-1:0]   r_k_d;
  logic [BIT_SIZE-1:0]   r_x;
  logic [BIT_SIZE-1:0]   r_x_bar;
  logic [BIT_SIZE-1:0]   r_k;
  logic [BIT_SIZE-1:0]   r_k_bar;
  logic [BIT_SIZE-1:0]   r_s_cap;
  logic [CNT_W-1:0]      r_match_count;
  logic [SETTLE_W-1:0]   r_n;
  logic [SETTLE_W-1:0]   r_cnt;
  logic                  r_busy;
  logic                  r_done;

  logic [SETTLE_W-1:0]   w_settle_n;
  logic [CNT_W-1:0]      w_popcnt;

  function automatic logic [CNT_W-1:0] popcount(input logic [BIT_SIZE-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < BIT_SIZE; i++) begin
      acc = acc + CNT_W'(v[i]);
    end
    return acc;
  endfunction

  assign w_settle_n = (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;
  assign w_popcnt   = popcount(r_s_cap);

  // Rails are only ever loaded from neutral (PRE) and only ever returned to neutral
  // (last DRIVE edge), so a pair can never be driven to both 1 or switch driven-to-driven.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state       <= ST_IDLE;
      r_x_sh        <= '0;
      r_k_sh        <= '0;
      r_x_d         <= '0;
      r_k_d         <= '0;
      r_x           <= '0;
      r_x_bar       <= '0;
      r_k           <= '0;
      r_k_bar       <= '0;
      r_s_cap       <= '0;
      r_match_count <= '0;
      r_n           <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      if (wr_en) begin
        case (wr_addr)
          2'd0:    r_x_sh[31:0]  <= wr_data;
          2'd1:    r_x_sh[63:32] <= wr_data;
          2'd2:    r_k_sh[31:0]  <= wr_data;
          default: r_k_sh[63:32] <= wr_data;
        endcase
      end

      r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_PRE;
            r_busy  <= 1'b1;
            r_n     <= w_settle_n;
            r_x_d   <= r_x_sh;
            r_k_d   <= r_k_sh;
          end
        end
        ST_PRE: begin
          r_state <= ST_DRIVE;
          r_cnt   <= r_n;
          r_x     <= r_x_d;
          r_x_bar <= ~r_x_d;
          r_k     <= r_k_d;
          r_k_bar <= ~r_k_d;
        end
        ST_DRIVE: begin
          r_cnt <= r_cnt - SETTLE_W'(1);
          if (r_cnt == SETTLE_W'(1)) begin
            r_s_cap <= s_in;
            r_state <= ST_CAP;
            r_x     <= '0;
            r_x_bar <= '0;
            r_k     <= '0;
            r_k_bar <= '0;
          end
        end
        ST_CAP: begin
          r_match_count <= w_popcnt;
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign x           = r_x;
  assign x_bar       = r_x_bar;
  assign k           = r_k;
  assign k_bar       = r_k_bar;
  assign s_cap       = r_s_cap;
  assign match_count = r_match_count;

endmodule

// File: tb/tb_bitsixtyfour_drive_capture.sv
// Directed bench for bitsixtyfour_drive_capture: cycle-by-cycle checks of the
// PRE/DRIVE/CAP sequence plus a continuous rail-safety monitor.
module tb_bitsixtyfour_drive_capture;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic [7:0]  settle_cycles;
  logic        busy;
  logic        done;
  logic [63:0] x, x_bar, k, k_bar;
  logic [63:0] s_in;
  logic [63:0] s_cap;
  logic [6:0]  match_count;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] XA  = 64'h00000000_FFFFFFFF;
  localparam logic [63:0] KA  = 64'hAAAAAAAA_55555555;
  localparam logic [63:0] ONE = 64'hFFFFFFFF_FFFFFFFF;

  bitsixtyfour_drive_capture #(.BIT_SIZE(64), .SETTLE_W(8), .CNT_W(7)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .settle_cycles(settle_cycles),
    .busy         (busy),
    .done         (done),
    .x            (x),
    .x_bar        (x_bar),
    .k            (k),
    .k_bar        (k_bar),
    .s_in         (s_in),
    .s_cap        (s_cap),
    .match_count  (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Rail safety on every cycle: no pair both high, no driven-to-driven switch.
  logic [255:0] prev_rails = '0;
  always @(negedge clk) begin
    logic [255:0] cur;
    logic         bad;
    cur = {x, x_bar, k, k_bar};
    bad = (prev_rails != '0) && (cur != '0) && (cur != prev_rails);
    chk("x_pair_overlap", x & x_bar, 64'h0);
    chk("k_pair_overlap", k & k_bar, 64'h0);
    chk("rail_direct_switch", {63'h0, bad}, 64'h0);
    prev_rails = cur;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [63:0] xv, input logic [63:0] kv);
    wr(2'd0, xv[31:0]);
    wr(2'd1, xv[63:32]);
    wr(2'd2, kv[31:0]);
    wr(2'd3, kv[63:32]);
  endtask

  task automatic chk_rails0(input string tag);
    chk({tag, "_x"}, x, 64'h0);
    chk({tag, "_xb"}, x_bar, 64'h0);
    chk({tag, "_k"}, k, 64'h0);
    chk({tag, "_kb"}, k_bar, 64'h0);
  endtask

  // Full operation from start to done; mid_wr writes k=all-ones during DRIVE 1/2,
  // mid_start pulses start during DRIVE 1.
  task automatic do_op(input logic [7:0] settle, input logic [63:0] ex, input logic [63:0] ek,
                       input logic [63:0] sin, input int ecnt, input bit mid_wr, input bit mid_start);
    int n;
    n = (settle == 8'd0) ? 1 : int'(settle);
    s_in = sin;
    settle_cycles = settle;
    start = 1'b1;
    tick;
    start = 1'b0;
    wr_en = 1'b0;
    settle_cycles = 8'hFF;
    @(negedge clk);
    chk("pre_busy", {63'h0, busy}, 64'h1);
    chk("pre_done", {63'h0, done}, 64'h0);
    chk_rails0("pre");
    for (int i = 1; i <= n; i++) begin
      tick;
      wr_en = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("drv_x", x, ex);
      chk("drv_xb", x_bar, ~ex);
      chk("drv_k", k, ek);
      chk("drv_kb", k_bar, ~ek);
      chk("drv_busy", {63'h0, busy}, 64'h1);
      if (mid_wr && i == 1) begin wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'hFFFFFFFF; end
      if (mid_wr && i == 2) begin wr_en = 1'b1; wr_addr = 2'd3; wr_data = 32'hFFFFFFFF; end
      if (mid_start && i == 1) start = 1'b1;
    end
    tick;
    wr_en = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_rails0("cap");
    chk("cap_scap", s_cap, sin);
    chk("cap_busy", {63'h0, busy}, 64'h1);
    chk("cap_done", {63'h0, done}, 64'h0);
    tick;
    @(negedge clk);
    chk("done_pulse", {63'h0, done}, 64'h1);
    chk("done_count", {57'h0, match_count}, 64'(ecnt));
    chk("done_busy", {63'h0, busy}, 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'hDEADBEEF;
    start = 1'b1;
    settle_cycles = 8'd3;
    s_in = ONE;
    tick;
    tick;
    rst = 1'b0;
    wr_en = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_rails0("rst");
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_count", {57'h0, match_count}, 64'h0);
    chk("rst_scap", s_cap, 64'h0);

    // Shadows must be zero after reset (write during reset ignored)
    do_op(8'd1, 64'h0, 64'h0, 64'h0, 0, 1'b0, 1'b0);

    load(XA, KA);
    do_op(8'd4, XA, KA, ~(XA ^ KA), 32, 1'b0, 1'b0);

    // settle 0 -> single DRIVE cycle; second start lands in the done cycle
    do_op(8'd0, XA, KA, 64'h00000000_0000000F, 4, 1'b0, 1'b0);
    do_op(8'd1, XA, KA, 64'h80000000_00000001, 2, 1'b0, 1'b0);
    tick;
    @(negedge clk);
    chk("done_fall", {63'h0, done}, 64'h0);
    chk("hold_count", {57'h0, match_count}, 64'h2);
    chk("hold_scap", s_cap, 64'h80000000_00000001);

    // Write in the start cycle and mid-DRIVE must not disturb the running op
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h12345678;
    do_op(8'd3, XA, KA, ~(XA ^ KA), 32, 1'b1, 1'b1);
    do_op(8'd2, 64'h00000000_12345678, ONE, ONE, 64, 1'b0, 1'b0);

    // Reset during DRIVE cycle 2
    settle_cycles = 8'd5;
    s_in = ONE;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    @(negedge clk);
    chk("rst_mid_d1_x", x, 64'h00000000_12345678);
    tick;
    @(negedge clk);
    chk("rst_mid_d2_kb", k_bar, 64'h0);
    chk("rst_mid_d2_busy", {63'h0, busy}, 64'h1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk_rails0("rst_mid");
    chk("rst_mid_busy", {63'h0, busy}, 64'h0);
    chk("rst_mid_scap", s_cap, 64'h0);
    chk("rst_mid_count", {57'h0, match_count}, 64'h0);
    chk("rst_mid_done", {63'h0, done}, 64'h0);
    for (int i = 0; i < 8; i++) begin
      tick;
      @(negedge clk);
      chk("rst_mid_no_done", {63'h0, done}, 64'h0);
      chk("rst_mid_idle", {63'h0, busy}, 64'h0);
    end
    do_op(8'd1, 64'h0, 64'h0, 64'h00000000_00000003, 2, 1'b0, 1'b0);

    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
